sample_source: RTL and testbench
================================

SAMPLE_SOURCE -- requirements
Module: sample_source

Interface
REQ-001 Parameter CNT_WIDTH, default 10: width of the sample index counter.
REQ-002 Parameter BURST_LEN, default 1000: samples per burst; legal range 1 to 2^CNT_WIDTH-1.
REQ-003 Parameter GAP_CYC, default 2: idle cycles inserted after each accepted sample; legal range 0 to 255.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: begin a burst; sampled only in IDLE.
REQ-007 Port abort, input, 1: terminate the burst in progress.
REQ-008 Port sample_ready, input, 1: downstream accepts the sample.
REQ-009 Port sample_valid, output, 1: sample_data is offered.
REQ-010 Port sample_data, output, 16: sample payload.
REQ-011 Port sample_idx, output, CNT_WIDTH: zero-based index of the offered sample.
REQ-012 Port busy, output, 1: high in any state other than IDLE.
REQ-013 Port burst_done, output, 1: one-cycle pulse when the final sample is accepted.

Function
REQ-014 The FSM SHALL have four states: IDLE, SEND, GAP and DONE.
REQ-015 IDLE SHALL go to SEND on the clock edge where start=1; sample_valid SHALL assert in the next cycle, giving 1-cycle latency.
REQ-016 In SEND, sample_valid SHALL be 1 and sample_data and sample_idx SHALL be held stable until a cycle with sample_ready=1 (a transfer).
REQ-017 On a transfer, sample_idx SHALL increment by 1 and the generator SHALL advance.
REQ-018 After a transfer, the FSM SHALL go to GAP when GAP_CYC>0 or stay in SEND when GAP_CYC=0, so back-to-back transfers are possible.
REQ-019 GAP SHALL hold sample_valid=0 for exactly GAP_CYC cycles and then return to SEND.
REQ-020 A transfer at sample_idx=BURST_LEN-1 SHALL go to DONE, bypassing GAP.
REQ-021 burst_done SHALL be 1 only during the single DONE cycle.
REQ-022 DONE SHALL go to IDLE unconditionally.
REQ-023 In IDLE, sample_idx SHALL be 0.
REQ-024 In the default build, sample_data SHALL equal sample_idx zero-extended to 16 bits.
REQ-025 abort=1 in SEND or GAP SHALL go to IDLE on the next edge with no burst_done pulse; a transfer in that same cycle still counts as accepted.
REQ-026 abort in IDLE or DONE SHALL be ignored.
REQ-027 start SHALL be ignored outside IDLE; start and abort together in IDLE SHALL start a burst.
REQ-028 sample_ready while sample_valid=0 SHALL have no effect.
REQ-029 BURST_LEN=1 SHALL give exactly one transfer followed by DONE.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, sample_valid=0, sample_idx=0, busy=0 and burst_done=0; sample_data SHALL reset to 0, or to the LFSR seed when SAMPLE_SOURCE_LFSR_EN is defined.
REQ-031 reset SHALL override start and abort and SHALL abandon any burst mid-operation, with no burst_done pulse.

Configuration
REQ-032 When the macro SAMPLE_SOURCE_LFSR_EN is defined, sample_data SHALL come from a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1).
REQ-033 With SAMPLE_SOURCE_LFSR_EN defined, the LFSR SHALL step once per transfer and reseed to 16'hACE1 on every IDLE-to-SEND entry.
REQ-034 With SAMPLE_SOURCE_LFSR_EN undefined, REQ-024 SHALL apply and no LFSR logic SHALL be present.

Verification
REQ-035 Defaults, start pulse, sample_ready held 1 -> 1000 transfers with sample_idx 0..999, 2 idle cycles between transfers, burst_done one cycle after transfer 999, busy low the cycle after that.
REQ-036 GAP_CYC=0, BURST_LEN=4, ready held 1 -> sample_valid high 4 consecutive cycles, sample_data 0,1,2,3, then burst_done.
REQ-037 Ready held 0 for 5 cycles at idx 7 -> sample_valid=1 and sample_data=7 stable for all 5 cycles; transfer on the first ready cycle.
REQ-038 abort at idx 500 during GAP -> IDLE next cycle, no burst_done; a new start restarts at idx 0.
REQ-039 reset asserted mid-burst at idx 300, and start during DONE -> all outputs 0 the cycle after reset; start in DONE is ignored.
REQ-040 With SAMPLE_SOURCE_LFSR_EN defined -> first three samples are 16'hACE1, 16'h5670, 16'hAB38, and the sequence repeats identically after a restart.

Source files
------------

// File: rtl/sample_source.sv
// sample_source: burst sample generator with valid/ready handshake.
// Optional build macro SAMPLE_SOURCE_LFSR_EN: when defined, sample_data comes
// from a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1); otherwise
// sample_data is the zero-extended sample index and no LFSR logic exists.
//
// state | meaning
// IDLE  | waiting for start, index held at 0
// SEND  | sample offered, waiting for sample_ready
// GAP   | idle cycles after an accepted sample
// DONE  | one-cycle burst_done pulse, then back to IDLE
module sample_source #(
    parameter int CNT_WIDTH = 10,
    parameter int BURST_LEN = 1000,
    parameter int GAP_CYC   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 sample_ready,
    output logic                 sample_valid,
    output logic [15:0]          sample_data,
    output logic [CNT_WIDTH-1:0] sample_idx,
    output logic                 busy,
    output logic                 burst_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BURST_LEN - 1);
    // Gap timer counts down to zero; loading GAP_CYC-1 gives exactly GAP_CYC
    // cycles in GAP.
    localparam logic [7:0] GAP_LOAD = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

    state_t     state;
    state_t     state_next;
    logic [7:0] gap_cnt;
    logic       transfer;

    assign transfer = (state == SEND) && sample_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_next   = state;
        sample_valid = 1'b0;
        busy         = 1'b1;
        burst_done   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                sample_valid = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (transfer) begin
                    if (sample_idx == LAST_IDX) begin
                        state_next = DONE;
                    end else if (GAP_CYC > 0) begin
                        state_next = GAP;
                    end else begin
                        state_next = SEND;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (gap_cnt == 8'd0) begin
                    state_next = SEND;
                end
            end
            DONE: begin
                burst_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sample index: cleared whenever the burst ends, advanced on each transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_idx <= '0;
        end else if ((state_next == IDLE) || (state_next == DONE)) begin
            sample_idx <= '0;
        end else if (transfer) begin
            sample_idx <= sample_idx + 1'b1;
        end
    end

    // Gap down-counter, loaded on every transfer and run while in GAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt <= 8'd0;
        end else if (transfer) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == GAP) && (gap_cnt != 8'd0)) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end

`ifdef SAMPLE_SOURCE_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr;

    // LFSR: reseeded at every burst start so each burst repeats the sequence,
    // stepped once per accepted sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if ((state == IDLE) && (state_next == SEND)) begin
            lfsr <= LFSR_SEED;
        end else if (transfer) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign sample_data = lfsr;
`else
    assign sample_data = 16'(sample_idx);
`endif

endmodule

// File: tb/tb_sample_source.sv
// Bench for sample_source: timestamp-based reference model of the burst
// protocol, directed scenarios followed by a randomized phase.
module tb_sample_source;

    localparam int W   = 10;
    localparam int BL  = 1000;
    localparam int GAP = 2;

    logic          clk;
    logic          reset;
    logic          start, abort, sample_ready;
    logic          sample_valid, busy, burst_done;
    logic [15:0]   sample_data;
    logic [W-1:0]  sample_idx;

    logic          start0, ready0;
    logic          valid0, busy0, done0;
    logic [15:0]   data0;
    logic [W-1:0]  idx0;

    sample_source #(.CNT_WIDTH(W), .BURST_LEN(BL), .GAP_CYC(GAP)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sample_ready(sample_ready), .sample_valid(sample_valid),
        .sample_data(sample_data), .sample_idx(sample_idx),
        .busy(busy), .burst_done(burst_done)
    );

    sample_source #(.CNT_WIDTH(W), .BURST_LEN(4), .GAP_CYC(0)) u_g0 (
        .clk(clk), .reset(reset), .start(start0), .abort(1'b0),
        .sample_ready(ready0), .sample_valid(valid0),
        .sample_data(data0), .sample_idx(idx0),
        .busy(busy0), .burst_done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int dut_xfers = 0;

    // Reference model: a burst is "active" from the start edge until it
    // finishes or is aborted; the next sample is due at cycle m_valid_at.
    int          cyc = 0;
    bit          m_active = 0;
    int          m_idx = 0;
    int          m_valid_at = 0;
    int          m_done_at = -10;
    logic [15:0] m_lfsr = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs against the model, apply inputs, advance.
    task automatic step(input logic st, input logic ab, input logic rd, input logic rs);
        bit e_valid, e_done, e_busy;
        start = st; abort = ab; sample_ready = rd; reset = rs;
        e_valid = m_active && (cyc >= m_valid_at);
        e_done  = (cyc == m_done_at);
        e_busy  = m_active || e_done;
        chk("valid", sample_valid, e_valid);
        chk("busy", busy, e_busy);
        chk("done", burst_done, e_done);
        if (!e_done) chk("idx", sample_idx, m_active ? m_idx : 0);
`ifdef SAMPLE_SOURCE_LFSR_EN
        if (e_valid) chk("data", sample_data, m_lfsr);
`else
        if (!e_done) chk("data", sample_data, m_active ? m_idx : 0);
`endif
        if (sample_valid === 1'b1 && rd && !rs) dut_xfers++;
        @(posedge clk);
        if (rs) begin
            m_active = 0; m_done_at = -10; m_lfsr = 16'hACE1;
        end else if (!e_busy) begin
            if (st) begin
                m_active = 1; m_idx = 0; m_valid_at = cyc + 1; m_lfsr = 16'hACE1;
            end
        end else if (m_active) begin
            if (e_valid && rd) begin
                m_lfsr = lfsr_step(m_lfsr);
                if (ab) m_active = 0;
                else if (m_idx == BL - 1) begin
                    m_active = 0; m_done_at = cyc + 1;
                end else begin
                    m_idx++; m_valid_at = cyc + 1 + GAP;
                end
            end else if (ab) begin
                m_active = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] l;
        int i;
        start = 0; abort = 0; sample_ready = 0; reset = 1;
        start0 = 0; ready0 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Zero-gap, 4-sample burst on the second instance, run twice.
        for (int rep = 0; rep < 2; rep++) begin
            l = 16'hACE1;
            ready0 = 1; start0 = 1;
            @(posedge clk); @(negedge clk);
            start0 = 0;
            for (int k = 0; k < 4; k++) begin
                chk("g0_valid", valid0, 1);
                chk("g0_idx", idx0, k);
`ifdef SAMPLE_SOURCE_LFSR_EN
                chk("g0_data", data0, l);
`else
                chk("g0_data", data0, k);
`endif
                l = lfsr_step(l);
                @(posedge clk); @(negedge clk);
            end
            chk("g0_done", done0, 1);
            chk("g0_valid_done", valid0, 0);
            @(posedge clk); @(negedge clk);
            chk("g0_busy_after", busy0, 0);
            chk("g0_done_after", done0, 0);
            ready0 = 0;
        end

        // Full default burst, ready held high.
        dut_xfers = 0;
        step(1, 0, 1, 0);
        for (i = 0; i < 3100 && burst_done !== 1'b1; i++) step(0, 0, 1, 0);
        chk("done_reached", burst_done, 1);
        chk("burst_xfers", dut_xfers, BL);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Back-pressure at idx 7, then abort during GAP at idx 500, restart.
        step(1, 1, 1, 0);
        for (i = 0; i < 100 && !(sample_valid === 1'b1 && sample_idx == 7); i++) step(0, 0, 1, 0);
        chk("reach_idx7", sample_idx, 7);
        repeat (5) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (i = 0; i < 2000 && !(busy === 1'b1 && sample_valid === 1'b0 && sample_idx == 500); i++)
            step(0, 0, 1, 0);
        chk("reach_idx500_gap", sample_idx, 500);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Reset mid-burst at idx 300.
        for (i = 0; i < 1500 && sample_idx != 300; i++) step(0, 0, 1, 0);
        chk("reach_idx300", sample_idx, 300);
        step(1, 1, 1, 1);
        step(0, 0, 1, 0);

        // Full burst with start held through DONE: must land in IDLE afterwards.
        step(1, 0, 1, 0);
        for (i = 0; i < 3100 && burst_done !== 1'b1; i++) step(1, 0, 1, 0);
        chk("done_reached2", burst_done, 1);
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Randomized phase.
        for (int n = 0; n < 6000; n++) begin
            logic st, ab, rd, rs;
            st = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 2999) == 0);
            rd = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 1999) == 0);
            step(st, ab, rd, rs);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
